visor_bpu: RTL and testbench

- Parametrised breakpoint/step unit; the next generation of the visor debug path.
- Sits between the target Synapse316 and its code ROM, and is driven by the supervisor MCU's registers.
- Provides NUM_BP masked breakpoints, multi-instruction stepping, halted-mode instruction injection, an exr shadow, and a circular trace of retired fetch addresses.

---
 rtl/visor_pkg.sv | 20 ++
 rtl/visor_bpu_if.sv | 27 ++
 rtl/visor_trace_buf.sv | 62 ++++++
 rtl/visor_bpu.sv | 190 +++++++++++++++++++
 tb/tb_visor_bpu.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/visor_pkg.sv
// visor_pkg: shared types and helpers for the visor breakpoint/step unit.
//   state_e  - debug state of the target (RUN / HALTED / STEPPING)
//   STATE_W  - width of the encoded state
//   idx_w()  - index width for a power-of-two table (at least 1 bit)
package visor_pkg;

    localparam int STATE_W         = 2;
    localparam int TRACE_DEPTH_DEF = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_HALTED   = 2'd1,
        ST_STEPPING = 2'd2
    } state_e;

    function automatic int idx_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/visor_bpu_if.sv
// visor_bpu_if: code bus between the target CPU, its code ROM and the
// breakpoint unit.
//   rom_code_in / rom_code_ready  - instruction and valid from the ROM
//   tg_code_addr / tg_loading_exr - fetch address and exr load from the target
//   tg_code_in / tg_code_ready    - instruction and ready towards the target
// The breakpoint unit uses the slave modport; the environment uses master.
interface visor_bpu_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int CODE_WIDTH = 16
);
    logic [CODE_WIDTH-1:0] rom_code_in;
    logic                  rom_code_ready;
    logic [ADDR_WIDTH-1:0] tg_code_addr;
    logic                  tg_loading_exr;
    logic [CODE_WIDTH-1:0] tg_code_in;
    logic                  tg_code_ready;

    modport master (
        output rom_code_in, rom_code_ready, tg_code_addr, tg_loading_exr,
        input  tg_code_in, tg_code_ready
    );

    modport slave (
        input  rom_code_in, rom_code_ready, tg_code_addr, tg_loading_exr,
        output tg_code_in, tg_code_ready
    );
endinterface

// File: rtl/visor_trace_buf.sv
// visor_trace_buf: circular buffer of the most recent DEPTH written words.
//   wr_en/wr_data - append one entry (oldest overwritten when full)
//   clr           - empty the buffer; wins over a same-cycle write
//   rd_idx        - 0 selects the newest entry; rd_data is combinational
//   count         - number of valid entries, saturating at DEPTH
module visor_trace_buf
    import visor_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEF,
    parameter int WIDTH = 16,
    localparam int IDX_W = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic [IDX_W:0]   count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [IDX_W-1:0] rd_ptr;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            // DEPTH is a power of two, so the pointer wraps by overflow
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
            if (count_q != (IDX_W+1)'(DEPTH))
                count_d = count_q + (IDX_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Newest entry sits just behind the write pointer
    assign rd_ptr  = wr_ptr_q - IDX_W'(1) - rd_idx;
    assign rd_data = mem_q[rd_ptr];
    assign count   = count_q;

endmodule

// File: rtl/visor_bpu.sv
// visor_bpu: breakpoint / step unit between the target CPU and its code ROM.
//   sysclk, sysreset_n        - clock, asynchronous active-low reset
//   bus (slave)               - ROM/target code bus, see visor_bpu_if
//   bp_addr/mask_flat, bp_en  - NUM_BP masked comparators (bp0 in the LSBs)
//   bp_load                   - per-breakpoint reprogram pulse, clears hit bit
//   run/halt/step_cmd         - level commands, acted on at rising edges
//   step_count                - instructions per step (0 means 1)
//   inject_*                  - halted-mode instruction injection
//   trace_*                   - circular trace of retired fetch addresses
//   bp_hit_vec, exr_shadow, state, step_remaining - status
module visor_bpu
    import visor_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int CODE_WIDTH   = 16,
    parameter int NUM_BP       = 4,
    parameter int STEP_WIDTH   = 8,
    parameter int TRACE_DEPTH  = TRACE_DEPTH_DEF,
    parameter bit RESET_HALTED = 1'b0,
    localparam int TRACE_IDX_W = idx_w(TRACE_DEPTH)
) (
    input  logic                         sysclk,
    input  logic                         sysreset_n,
    visor_bpu_if.slave                   bus,
    input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr_flat,
    input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_mask_flat,
    input  logic [NUM_BP-1:0]            bp_en,
    input  logic [NUM_BP-1:0]            bp_load,
    input  logic                         run_cmd,
    input  logic                         halt_cmd,
    input  logic                         step_cmd,
    input  logic [STEP_WIDTH-1:0]        step_count,
    input  logic                         inject_en,
    input  logic [CODE_WIDTH-1:0]        inject_code,
    input  logic                         inject_strobe,
    input  logic                         trace_clr,
    input  logic [TRACE_IDX_W-1:0]       trace_rd_idx,
    output logic [ADDR_WIDTH-1:0]        trace_rd_data,
    output logic [TRACE_IDX_W:0]         trace_count,
    output logic [NUM_BP-1:0]            bp_hit_vec,
    output logic [CODE_WIDTH-1:0]        exr_shadow,
    output logic [STATE_W-1:0]           state,
    output logic [STEP_WIDTH-1:0]        step_remaining
);

    localparam state_e RST_STATE = RESET_HALTED ? ST_HALTED : ST_RUN;

    state_e                state_q, state_d;
    logic [STEP_WIDTH-1:0] step_rem_q, step_rem_d;
    logic                  skip_q, skip_d;
    logic [NUM_BP-1:0]     hit_q, hit_d;
    logic [CODE_WIDTH-1:0] exr_q, exr_d;
    logic                  run_prev_q, halt_prev_q, step_prev_q, inj_prev_q;

    logic [NUM_BP-1:0]     match;
    logic                  any_match;
    logic                  run_edge, halt_edge, step_edge, inj_edge;
    logic                  code_ready;
    logic                  retire;
    logic                  trace_wr;

    // Masked comparators: a set mask bit makes that address bit don't-care
    for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_cmp
        assign match[gi] = bp_en[gi] &&
            (((bus.tg_code_addr ^ bp_addr_flat[gi*ADDR_WIDTH +: ADDR_WIDTH])
              & ~bp_mask_flat[gi*ADDR_WIDTH +: ADDR_WIDTH]) == '0);
    end

    // skip suppresses the breakpoint we were just resumed from
    assign any_match = (|match) && (state_q == ST_RUN) && !skip_q;

    assign run_edge  = run_cmd       && !run_prev_q;
    assign halt_edge = halt_cmd      && !halt_prev_q;
    assign step_edge = step_cmd      && !step_prev_q;
    assign inj_edge  = inject_strobe && !inj_prev_q;

    // Ready is gated in the same cycle as the match so a breakpointed
    // fetch never reaches the target.
    always_comb begin
        code_ready = 1'b0;
        case (state_q)
            ST_RUN:      code_ready = bus.rom_code_ready && !any_match;
            ST_STEPPING: code_ready = bus.rom_code_ready;
            ST_HALTED:   code_ready = inject_en && inj_edge;
            default:     code_ready = 1'b0;
        endcase
    end

    assign bus.tg_code_ready = code_ready;
    assign bus.tg_code_in    = (state_q == ST_HALTED && inject_en) ? inject_code
                                                                   : bus.rom_code_in;

    assign retire   = code_ready && bus.tg_loading_exr;
    // The only retire possible while halted is an injected one
    assign trace_wr = retire && (state_q != ST_HALTED);

    always_comb begin
        state_d    = state_q;
        step_rem_d = step_rem_q;
        skip_d     = skip_q;
        hit_d      = hit_q;
        exr_d      = exr_q;

        if (any_match)
            hit_d = hit_q | match;
        if (retire)
            skip_d = 1'b0;
        if (bus.tg_loading_exr)
            exr_d = bus.tg_code_in;

        case (state_q)
            ST_RUN: begin
                if (halt_edge || any_match)
                    state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (halt_edge) begin
                    state_d = ST_HALTED;
                end else if (step_edge) begin
                    state_d    = ST_STEPPING;
                    step_rem_d = (step_count == '0) ? STEP_WIDTH'(1) : step_count;
                end else if (run_edge) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b1;
                end
            end
            ST_STEPPING: begin
                if (retire) begin
                    if (step_rem_q <= STEP_WIDTH'(1)) begin
                        state_d    = ST_HALTED;
                        step_rem_d = '0;
                    end else begin
                        step_rem_d = step_rem_q - STEP_WIDTH'(1);
                    end
                end
                // Abandoned step keeps its remainder visible as status
                if (halt_edge)
                    state_d = ST_HALTED;
            end
            default: state_d = ST_HALTED;
        endcase

        // Reprogramming a breakpoint wins over a same-cycle hit
        hit_d = hit_d & ~bp_load;
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state_q     <= RST_STATE;
            step_rem_q  <= '0;
            skip_q      <= 1'b0;
            hit_q       <= '0;
            exr_q       <= '0;
            run_prev_q  <= 1'b0;
            halt_prev_q <= 1'b0;
            step_prev_q <= 1'b0;
            inj_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_rem_q  <= step_rem_d;
            skip_q      <= skip_d;
            hit_q       <= hit_d;
            exr_q       <= exr_d;
            run_prev_q  <= run_cmd;
            halt_prev_q <= halt_cmd;
            step_prev_q <= step_cmd;
            inj_prev_q  <= inject_strobe;
        end
    end

    visor_trace_buf #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_trace (
        .clk     (sysclk),
        .rst_n   (sysreset_n),
        .wr_en   (trace_wr),
        .wr_data (bus.tg_code_addr),
        .clr     (trace_clr),
        .rd_idx  (trace_rd_idx),
        .rd_data (trace_rd_data),
        .count   (trace_count)
    );

    assign bp_hit_vec     = hit_q;
    assign exr_shadow     = exr_q;
    assign state          = state_q;
    assign step_remaining = step_rem_q;

endmodule

// File: tb/tb_visor_bpu.sv
// Directed testbench for visor_bpu: breakpoints, stepping, resume past a
// breakpoint, injection, trace wrap/clear and asynchronous reset.
module tb_visor_bpu;

    localparam int AW = 16;
    localparam int CW = 16;
    localparam int NB = 4;
    localparam int SW = 8;
    localparam int TD = 8;
    localparam int IW = 3;

    logic              sysclk = 1'b0;
    logic              sysreset_n;
    logic [NB*AW-1:0]  bp_addr_flat;
    logic [NB*AW-1:0]  bp_mask_flat;
    logic [NB-1:0]     bp_en;
    logic [NB-1:0]     bp_load;
    logic              run_cmd, halt_cmd, step_cmd;
    logic [SW-1:0]     step_count;
    logic              inject_en;
    logic [CW-1:0]     inject_code;
    logic              inject_strobe;
    logic              trace_clr;
    logic [IW-1:0]     trace_rd_idx;
    logic [AW-1:0]     trace_rd_data;
    logic [IW:0]       trace_count;
    logic [NB-1:0]     bp_hit_vec;
    logic [CW-1:0]     exr_shadow;
    logic [1:0]        state;
    logic [SW-1:0]     step_remaining;

    int checks = 0;
    int errors = 0;

    visor_bpu_if #(.ADDR_WIDTH(AW), .CODE_WIDTH(CW)) bus ();

    // ROM model: instruction word is the address with a fixed tag
    assign bus.rom_code_in = bus.tg_code_addr ^ 16'hA000;

    visor_bpu #(
        .ADDR_WIDTH(AW), .CODE_WIDTH(CW), .NUM_BP(NB), .STEP_WIDTH(SW),
        .TRACE_DEPTH(TD), .RESET_HALTED(1'b0)
    ) dut (
        .sysclk         (sysclk),
        .sysreset_n     (sysreset_n),
        .bus            (bus),
        .bp_addr_flat   (bp_addr_flat),
        .bp_mask_flat   (bp_mask_flat),
        .bp_en          (bp_en),
        .bp_load        (bp_load),
        .run_cmd        (run_cmd),
        .halt_cmd       (halt_cmd),
        .step_cmd       (step_cmd),
        .step_count     (step_count),
        .inject_en      (inject_en),
        .inject_code    (inject_code),
        .inject_strobe  (inject_strobe),
        .trace_clr      (trace_clr),
        .trace_rd_idx   (trace_rd_idx),
        .trace_rd_data  (trace_rd_data),
        .trace_count    (trace_count),
        .bp_hit_vec     (bp_hit_vec),
        .exr_shadow     (exr_shadow),
        .state          (state),
        .step_remaining (step_remaining)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-16s ok  value=%h", tag, obs);
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    // Target presents a fetch for one cycle; ready is checked before the edge
    task automatic fetch(input logic [AW-1:0] a, input logic exp_ready);
        bus.tg_code_addr   = a;
        bus.tg_loading_exr = 1'b1;
        #2;
        chk($sformatf("ready@%h", a), 32'(bus.tg_code_ready), 32'(exp_ready));
        cyc();
    endtask

    task automatic chk_trace(input logic [IW-1:0] idx, input logic [AW-1:0] exp);
        trace_rd_idx = idx;
        #1;
        chk($sformatf("trace[%0d]", idx), 32'(trace_rd_data), 32'(exp));
    endtask

    initial begin
        sysreset_n         = 1'b0;
        bus.rom_code_ready = 1'b1;
        bus.tg_code_addr   = '0;
        bus.tg_loading_exr = 1'b0;
        bp_addr_flat = '0; bp_mask_flat = '0; bp_en = '0; bp_load = '0;
        run_cmd = 0; halt_cmd = 0; step_cmd = 0; step_count = '0;
        inject_en = 0; inject_code = '0; inject_strobe = 0;
        trace_clr = 0; trace_rd_idx = '0;

        // Reset state
        repeat (2) @(posedge sysclk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_hit", 32'(bp_hit_vec), 32'd0);
        chk("rst_count", 32'(trace_count), 32'd0);
        chk("rst_exr", 32'(exr_shadow), 32'd0);
        chk("rst_rem", 32'(step_remaining), 32'd0);
        sysreset_n = 1'b1;
        cyc();

        // Exact breakpoint at 0x0010
        bp_addr_flat[15:0] = 16'h0010;
        bp_en = 4'b0001;
        for (int i = 0; i < 4; i++) fetch(16'h000C + 16'(i), 1'b1);
        chk("exr_0f", 32'(exr_shadow), 32'hA00F);
        fetch(16'h0010, 1'b0);
        chk("bp0_state", 32'(state), 32'd1);
        chk("bp0_hit", 32'(bp_hit_vec), 32'b0001);
        chk("bp0_count", 32'(trace_count), 32'd4);
        chk_trace(0, 16'h000F);
        chk_trace(3, 16'h000C);

        // Step 3 from 0x0010
        step_count = 8'd3;
        step_cmd   = 1'b1;
        #2;
        chk("step_edge_rdy", 32'(bus.tg_code_ready), 32'd0);
        cyc();
        step_cmd = 1'b0;
        chk("step_state", 32'(state), 32'd2);
        chk("step_rem3", 32'(step_remaining), 32'd3);
        fetch(16'h0010, 1'b1);
        chk("step_rem2", 32'(step_remaining), 32'd2);
        fetch(16'h0011, 1'b1);
        fetch(16'h0012, 1'b1);
        chk("step_done", 32'(state), 32'd1);
        chk("step_rem0", 32'(step_remaining), 32'd0);
        fetch(16'h0013, 1'b0);
        chk("step_count7", 32'(trace_count), 32'd7);

        // Step with count 0 behaves as 1
        step_count = 8'd0;
        step_cmd   = 1'b1;
        cyc();
        step_cmd = 1'b0;
        chk("step0_rem", 32'(step_remaining), 32'd1);
        fetch(16'h0013, 1'b1);
        chk("step0_state", 32'(state), 32'd1);
        chk("step0_count", 32'(trace_count), 32'd8);
        chk_trace(0, 16'h0013);

        // Resume at the breakpoint address: no re-halt, later loop halts
        bus.tg_code_addr = 16'h0010;
        run_cmd = 1'b1;
        cyc();
        run_cmd = 1'b0;
        chk("run_state", 32'(state), 32'd0);
        fetch(16'h0010, 1'b1);
        fetch(16'h0011, 1'b1);
        chk("run_cont", 32'(state), 32'd0);
        fetch(16'h0010, 1'b0);
        chk("rehalt", 32'(state), 32'd1);
        chk("rehalt_hit", 32'(bp_hit_vec), 32'b0001);
        chk("sat_count", 32'(trace_count), 32'd8);
        chk_trace(0, 16'h0011);
        chk_trace(7, 16'h000E);

        // bp_load clears hit; masked breakpoint on bp1
        bp_load = 4'b0001;
        cyc();
        bp_load = '0;
        chk("load_clr", 32'(bp_hit_vec), 32'd0);
        bp_addr_flat[31:16] = 16'h0040;
        bp_mask_flat[31:16] = 16'h000F;
        bp_en = 4'b0011;
        bus.tg_code_addr = 16'h0030;
        run_cmd = 1'b1;
        cyc();
        run_cmd = 1'b0;
        fetch(16'h0030, 1'b1);
        fetch(16'h004B, 1'b0);
        chk("mask_state", 32'(state), 32'd1);
        chk("mask_hit", 32'(bp_hit_vec), 32'b0010);
        bus.tg_code_addr = 16'h0031;
        run_cmd = 1'b1;
        cyc();
        run_cmd = 1'b0;
        fetch(16'h0031, 1'b1);
        fetch(16'h0050, 1'b1);
        chk("nomatch_run", 32'(state), 32'd0);
        bus.tg_loading_exr = 1'b0;
        halt_cmd = 1'b1;
        cyc();
        halt_cmd = 1'b0;
        chk("halt_cmd", 32'(state), 32'd1);
        chk("halt_hit", 32'(bp_hit_vec), 32'b0010);

        // Injection while halted
        inject_en     = 1'b1;
        inject_code   = 16'h1234;
        bus.tg_loading_exr = 1'b1;
        inject_strobe = 1'b1;
        #2;
        chk("inj_code", 32'(bus.tg_code_in), 32'h1234);
        chk("inj_ready", 32'(bus.tg_code_ready), 32'd1);
        cyc();
        chk("inj_exr", 32'(exr_shadow), 32'h1234);
        chk("inj_1cyc", 32'(bus.tg_code_ready), 32'd0);
        chk("inj_count", 32'(trace_count), 32'd8);
        chk_trace(0, 16'h0050);
        inject_strobe = 1'b0;
        inject_en     = 1'b0;
        bus.tg_loading_exr = 1'b0;
        cyc();

        // Trace clear, wrap, and clear-vs-retire
        trace_clr = 1'b1;
        cyc();
        trace_clr = 1'b0;
        chk("clr_count", 32'(trace_count), 32'd0);
        bus.tg_code_addr = 16'h0100;
        run_cmd = 1'b1;
        cyc();
        run_cmd = 1'b0;
        for (int i = 0; i < 11; i++) fetch(16'h0100 + 16'(i), 1'b1);
        chk("wrap_count", 32'(trace_count), 32'd8);
        chk_trace(0, 16'h010A);
        chk_trace(7, 16'h0103);
        trace_clr = 1'b1;
        fetch(16'h010B, 1'b1);
        trace_clr = 1'b0;
        chk("clr_wins", 32'(trace_count), 32'd0);

        // Asynchronous reset in the middle of a step
        bus.tg_loading_exr = 1'b0;
        halt_cmd = 1'b1;
        cyc();
        halt_cmd = 1'b0;
        step_count = 8'd5;
        step_cmd   = 1'b1;
        cyc();
        step_cmd = 1'b0;
        chk("ar_stepping", 32'(state), 32'd2);
        fetch(16'h010C, 1'b1);
        chk("ar_rem4", 32'(step_remaining), 32'd4);
        #2;
        sysreset_n = 1'b0;
        #1;
        chk("ar_state", 32'(state), 32'd0);
        chk("ar_rem", 32'(step_remaining), 32'd0);
        chk("ar_hit", 32'(bp_hit_vec), 32'd0);
        chk("ar_count", 32'(trace_count), 32'd0);
        chk("ar_exr", 32'(exr_shadow), 32'd0);
        cyc();
        sysreset_n = 1'b1;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
